// File: rtl/memory_read_arbiter_if.sv
// Requester and memory-side signals of the memory read arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus the memory.
interface memory_read_arbiter_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 6
);
    logic              REQ0;
    logic [ADDR_W-1:0] ADD0;
    logic              GNT0;
    logic              VALID0;
    logic              REQ1;
    logic [ADDR_W-1:0] ADD1;
    logic              GNT1;
    logic              VALID1;
    logic [DATA_W-1:0] RDATA;
    logic              ERR;
    logic              OWNER;
    logic              BUSY;
    logic [ADDR_W-1:0] MEM_ADD;
    logic              MEM_RST;
    logic              MEM_CLR;
    logic [DATA_W-1:0] MEM_OUT;

    modport master (
        input  REQ0, ADD0, REQ1, ADD1, MEM_CLR, MEM_OUT,
        output GNT0, VALID0, GNT1, VALID1, RDATA, ERR, OWNER, BUSY, MEM_ADD, MEM_RST
    );

    modport slave (
        output REQ0, ADD0, REQ1, ADD1, MEM_CLR, MEM_OUT,
        input  GNT0, VALID0, GNT1, VALID1, RDATA, ERR, OWNER, BUSY, MEM_ADD, MEM_RST
    );
endinterface

// File: rtl/memory_read_arbiter.sv
// Shares one memory read port between two requesters: round-robin grant, wait for MEM_CLR low,
// return data (or flag a timeout), then re-arm the memory with a MEM_RST pulse.
module memory_read_arbiter #(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned DATA_W      = 6,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned REARM_CYC   = 1
) (
    input logic CLK,
    input logic RST,
    memory_read_arbiter_if.master bus
);
    localparam int unsigned WaitW  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned RearmW = $clog2(REARM_CYC + 1);

    typedef enum logic [1:0] {StIdle, StWait, StRearm} state_e;

    state_e              state_q, state_d;
    logic [WaitW-1:0]    wait_q, wait_d;
    logic [RearmW-1:0]   rearm_q, rearm_d;
    logic [ADDR_W-1:0]   mem_add_q, mem_add_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                owner_q, owner_d;
    logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                valid0_q, valid0_d, valid1_q, valid1_d;
    logic                err_q, err_d;
    logic                mem_rst_q, mem_rst_d;
    logic                busy_q, busy_d;
    logic                pick;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        rearm_d   = rearm_q;
        mem_add_d = mem_add_q;
        rdata_d   = rdata_q;
        owner_d   = owner_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        valid0_d  = 1'b0;
        valid1_d  = 1'b0;
        err_d     = 1'b0;
        // On a tie the requester that was not served last wins.
        pick      = (bus.REQ0 && bus.REQ1) ? ~owner_q : bus.REQ1;

        unique case (state_q)
            StIdle: begin
                if (bus.REQ0 || bus.REQ1) begin
                    owner_d   = pick;
                    mem_add_d = pick ? bus.ADD1 : bus.ADD0;
                    gnt0_d    = ~pick;
                    gnt1_d    = pick;
                    wait_d    = '0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                wait_d = wait_q + 1'b1;
                // MEM_CLR is still settling on the first WAIT cycle; completion beats timeout.
                if (wait_q != '0 && !bus.MEM_CLR) begin
                    rdata_d  = bus.MEM_OUT;
                    valid0_d = ~owner_q;
                    valid1_d = owner_q;
                    rearm_d  = '0;
                    state_d  = StRearm;
                end else if (wait_q == WaitW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    rearm_d = '0;
                    state_d = StRearm;
                end
            end
            StRearm: begin
                if (rearm_q == RearmW'(REARM_CYC - 1)) begin
                    state_d = StIdle;
                end else begin
                    rearm_d = rearm_q + 1'b1;
                end
            end
            default: state_d = StRearm;
        endcase

        mem_rst_d = (state_d == StRearm);
        busy_d    = (state_d != StIdle);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StRearm;
            wait_q    <= '0;
            rearm_q   <= '0;
            mem_add_q <= '0;
            rdata_q   <= '0;
            owner_q   <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            valid0_q  <= 1'b0;
            valid1_q  <= 1'b0;
            err_q     <= 1'b0;
            mem_rst_q <= 1'b1;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            rearm_q   <= rearm_d;
            mem_add_q <= mem_add_d;
            rdata_q   <= rdata_d;
            owner_q   <= owner_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            valid0_q  <= valid0_d;
            valid1_q  <= valid1_d;
            err_q     <= err_d;
            mem_rst_q <= mem_rst_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.GNT0    = gnt0_q;
    assign bus.GNT1    = gnt1_q;
    assign bus.VALID0  = valid0_q;
    assign bus.VALID1  = valid1_q;
    assign bus.RDATA   = rdata_q;
    assign bus.ERR     = err_q;
    assign bus.OWNER   = owner_q;
    assign bus.BUSY    = busy_q;
    assign bus.MEM_ADD = mem_add_q;
    assign bus.MEM_RST = mem_rst_q;
endmodule

// File: tb/tb_memory_read_arbiter.sv
// Directed bench for memory_read_arbiter; the memory answers on the 2nd WAIT cycle with
// MEM_OUT = MEM_ADD ^ 6'h20 (so address 5 reads 37, address 6 reads 38).
module tb_memory_read_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic mem_en;
    logic gnt_d = 1'b0;
    int   checks = 0;
    int   failures = 0;

    memory_read_arbiter_if #(.ADDR_W(6), .DATA_W(6)) bus ();

    memory_read_arbiter #(
        .ADDR_W(6), .DATA_W(6), .TIMEOUT_CYC(16), .REARM_CYC(1)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) gnt_d <= bus.GNT0 | bus.GNT1;
    assign bus.MEM_CLR = !(mem_en && gnt_d);
    assign bus.MEM_OUT = bus.MEM_ADD ^ 6'h20;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // {GNT0, GNT1, VALID0, VALID1, ERR}
    function automatic logic [4:0] pulses();
        return {bus.GNT0, bus.GNT1, bus.VALID0, bus.VALID1, bus.ERR};
    endfunction

    initial begin
        logic [4:0] seen;
        logic       exp_p;
        rst = 1'b1; mem_en = 1'b1;
        bus.REQ0 = 1'b0; bus.REQ1 = 1'b0; bus.ADD0 = '0; bus.ADD1 = '0;

        // 1: reset state, then one REARM cycle, then idle
        step(); step();
        check_eq("rst_mem_rst", bus.MEM_RST, 1);
        check_eq("rst_busy", bus.BUSY, 1);
        check_eq("rst_owner", bus.OWNER, 1);
        check_eq("rst_rdata", bus.RDATA, 0);
        check_eq("rst_mem_add", bus.MEM_ADD, 0);
        check_eq("rst_pulses", pulses(), 0);
        rst = 1'b0;
        step();
        check_eq("idle_busy", bus.BUSY, 0);
        check_eq("idle_mem_rst", bus.MEM_RST, 0);
        check_eq("idle_pulses", pulses(), 0);

        // 2: single read on port 0
        bus.REQ0 = 1'b1; bus.ADD0 = 6'd5;
        step();
        check_eq("t2_gnt0", pulses(), 5'b10000);
        check_eq("t2_mem_add", bus.MEM_ADD, 5);
        check_eq("t2_owner", bus.OWNER, 0);
        bus.REQ0 = 1'b0;
        step();
        check_eq("t2_wait_pulses", pulses(), 0);
        step();
        check_eq("t2_valid0", pulses(), 5'b00100);
        check_eq("t2_rdata", bus.RDATA, 37);
        check_eq("t2_rearm", bus.MEM_RST, 1);
        step();
        check_eq("t2_end_pulses", pulses(), 0);
        check_eq("t2_end_busy", bus.BUSY, 0);
        check_eq("t2_end_mem_rst", bus.MEM_RST, 0);

        // 3: contention; OWNER is 0, so port 1 goes first, then strict alternation
        bus.REQ0 = 1'b1; bus.REQ1 = 1'b1; bus.ADD1 = 6'd6;
        for (int k = 0; k < 4; k++) begin
            exp_p = (k % 2 == 0);
            step();
            check_eq("t3_gnt", pulses(), exp_p ? 5'b01000 : 5'b10000);
            check_eq("t3_mem_add", bus.MEM_ADD, exp_p ? 6 : 5);
            step();
            check_eq("t3_wait_pulses", pulses(), 0);
            step();
            check_eq("t3_valid", pulses(), exp_p ? 5'b00010 : 5'b00100);
            check_eq("t3_rdata", bus.RDATA, exp_p ? 38 : 37);
            if (k == 3) begin
                bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
            end
            step();
            check_eq("t3_idle_pulses", pulses(), 0);
        end

        // 4: timeout on port 1 with MEM_CLR stuck high
        mem_en = 1'b0;
        bus.REQ1 = 1'b1;
        step();
        check_eq("t4_gnt1", pulses(), 5'b01000);
        bus.REQ1 = 1'b0;
        seen = '0;
        for (int i = 1; i < 16; i++) begin
            step();
            seen |= pulses();
        end
        check_eq("t4_early_pulses", seen, 0);
        step();
        check_eq("t4_err", pulses(), 5'b00001);
        check_eq("t4_rdata_kept", bus.RDATA, 37);
        check_eq("t4_rearm", bus.MEM_RST, 1);
        check_eq("t4_owner", bus.OWNER, 1);
        step();
        check_eq("t4_end_pulses", pulses(), 0);
        check_eq("t4_end_busy", bus.BUSY, 0);
        mem_en = 1'b1;

        // 5: inputs changed while busy are ignored
        bus.REQ0 = 1'b1; bus.ADD0 = 6'd5;
        step();
        check_eq("t5_gnt0", pulses(), 5'b10000);
        bus.REQ0 = 1'b0; bus.ADD0 = 6'd6; bus.REQ1 = 1'b1;
        step();
        bus.REQ1 = 1'b0;
        check_eq("t5_mem_add_wait", bus.MEM_ADD, 5);
        step();
        check_eq("t5_valid0", pulses(), 5'b00100);
        check_eq("t5_rdata", bus.RDATA, 37);
        check_eq("t5_mem_add_rearm", bus.MEM_ADD, 5);
        step();
        check_eq("t5_idle_pulses", pulses(), 0);
        check_eq("t5_idle_busy", bus.BUSY, 0);
        step();
        check_eq("t5_no_gnt1", pulses(), 0);

        // 6: reset during WAIT drops the access, then a clean read
        bus.REQ0 = 1'b1;
        step();
        check_eq("t6_gnt0", pulses(), 5'b10000);
        bus.REQ0 = 1'b0; rst = 1'b1;
        step();
        check_eq("t6_rst_pulses", pulses(), 0);
        check_eq("t6_rst_mem_rst", bus.MEM_RST, 1);
        check_eq("t6_rst_busy", bus.BUSY, 1);
        check_eq("t6_rst_rdata", bus.RDATA, 0);
        check_eq("t6_rst_owner", bus.OWNER, 1);
        rst = 1'b0;
        step();
        check_eq("t6_idle_busy", bus.BUSY, 0);
        check_eq("t6_idle_pulses", pulses(), 0);
        bus.REQ0 = 1'b1;
        step();
        check_eq("t6_regnt0", pulses(), 5'b10000);
        check_eq("t6_mem_add", bus.MEM_ADD, 6);
        bus.REQ0 = 1'b0;
        step();
        step();
        check_eq("t6_valid0", pulses(), 5'b00100);
        check_eq("t6_rdata", bus.RDATA, 38);
        step();
        check_eq("t6_end_busy", bus.BUSY, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
